mac_booth_radix4_acc: RTL and testbench

Parametrised radix-4 Booth multiply-accumulate engine with per-operation signed/unsigned mode, configurable digits per cycle and a persistent wide accumulator. Each accepted operand pair is multiplied by iterative CSA accumulation of Booth partial products. The product is then added to the running accumulator, or replaces it, in one final CPA cycle. It is the next-generation iterative multiplier for the EPU datapath, with valid/ready handshakes on both sides.

---
 rtl/mac_booth_pkg.sv | 34 +++
 rtl/booth_pp_gen.sv | 30 +++
 rtl/mac_booth_radix4_acc.sv | 203 ++++++++++++++++++++
 tb/tb_mac_booth_radix4_acc.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiply-accumulate engine.
package mac_booth_pkg;

    typedef logic signed [2:0] booth_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic int booth_digits(input int mul_len);
        return mul_len / 2 + 1;
    endfunction

    function automatic int booth_ncyc(input int mul_len, input int dpc);
        return (booth_digits(mul_len) + dpc - 1) / dpc;
    endfunction

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_rec(input logic [2:0] win);
        booth_digit_t d;
        case (win)
            3'b001, 3'b010: d = 3'sd1;
            3'b011:         d = 3'sd2;
            3'b100:         d = -3'sd2;
            3'b101, 3'b110: d = -3'sd1;
            default:        d = 3'sd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One Booth partial product: digit(window) * a_ext * 4^shift, PW bits, two's-complement negation.
module booth_pp_gen
    import mac_booth_pkg::*;
#(
    parameter int PW = 50,
    parameter int SW = 5
) (
    input  logic [2:0]    win_i,
    input  logic [PW-1:0] a_ext_i,
    input  logic [SW-1:0] shift_i,
    output logic [PW-1:0] pp_o
);

    booth_digit_t  digit;
    logic [PW-1:0] mag;
    logic [PW-1:0] sgnd;

    always_comb begin
        digit = booth_rec(win_i);
        mag   = '0;
        if (digit == 3'sd2 || digit == -3'sd2) begin
            mag = a_ext_i << 1;
        end else if (digit != 3'sd0) begin
            mag = a_ext_i;
        end
        sgnd = digit[2] ? (-mag) : mag;
        pp_o = sgnd << {shift_i, 1'b0};
    end

endmodule

// File: rtl/mac_booth_radix4_acc.sv
// Iterative radix-4 Booth MAC: DPC digits/cycle into CSA sum/carry, one CPA cycle into a persistent accumulator.
// Optional clamping with sticky ovf when MAC_BOOTH_SAT_EN is defined; otherwise results wrap and ovf is 0.
module mac_booth_radix4_acc
    import mac_booth_pkg::*;
#(
    parameter int MUL_LEN = 24,
    parameter int ACC_LEN = 56,
    parameter int DPC     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MUL_LEN-1:0] a,
    input  logic [MUL_LEN-1:0] b,
    input  logic               is_signed,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_LEN-1:0] result,
    output logic               ovf
);

    localparam int PW     = 2 * MUL_LEN + 2;
    localparam int BWX    = MUL_LEN + 3 + 2 * DPC;
    localparam int DIGITS = booth_digits(MUL_LEN);
    localparam int NCYC   = booth_ncyc(MUL_LEN, DPC);
    localparam int CW     = $clog2(NCYC * DPC + DPC + 1);
    localparam int TB     = (PW < ACC_LEN + 1) ? PW : ACC_LEN + 1;
`ifdef MAC_BOOTH_SAT_EN
    localparam int LX     = ACC_LEN + 2;
`else
    localparam int LX     = ACC_LEN;
`endif

    state_t             state_q, state_d;
    logic [PW-1:0]      a_q;
    logic [BWX-1:0]     b_q;
    logic               sgn_q, clr_q;
    logic [PW-1:0]      sum_q, sum_d, carry_q, carry_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ACC_LEN-1:0] res_q, res_d;
    logic               accept, last_run;
    logic [PW-1:0]      pp [DPC];
    logic [PW-1:0]      s_v, c_v, t_v;

    assign last_run = (cnt_q + CW'(DPC)) >= CW'(DIGITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_run) state_d = FIN;
            end
            FIN: state_d = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // b_q shifts right by 2*DPC per RUN cycle, so window j always sits at bits [2j+2:2j].
    for (genvar j = 0; j < DPC; j++) begin : g_pp
        logic [CW-1:0] idx;
        logic [2:0]    win;
        assign idx = cnt_q + CW'(j);
        assign win = (idx < CW'(DIGITS)) ? b_q[2*j+2:2*j] : 3'b000;
        booth_pp_gen #(
            .PW (PW),
            .SW (CW)
        ) u_pp (
            .win_i   (win),
            .a_ext_i (a_q),
            .shift_i (idx),
            .pp_o    (pp[j])
        );
    end

    always_comb begin
        s_v = sum_q;
        c_v = carry_q;
        t_v = '0;
        for (int j = 0; j < DPC; j++) begin
            t_v = s_v ^ c_v ^ pp[j];
            c_v = ((s_v & c_v) | (s_v & pp[j]) | (c_v & pp[j])) << 1;
            s_v = t_v;
        end
    end

    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (accept) begin
            sum_d   = '0;
            carry_d = '0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sum_d   = s_v;
            carry_d = c_v;
            cnt_d   = cnt_q + CW'(DPC);
        end
    end

    // Final CPA; the product is truncated to TB bits and re-extended per the operation's mode.
    logic [PW-1:0] p_raw;
    logic          p_ext_bit;
    logic [LX-1:0] p_l, acc_l, sum_l;

    assign p_raw     = sum_q + carry_q;
    assign p_ext_bit = sgn_q & p_raw[TB-1];
    assign p_l       = LX'({{LX{p_ext_bit}}, p_raw[TB-1:0]});

`ifdef MAC_BOOTH_SAT_EN
    logic sat_hi, sat_lo, ovf_q;

    assign acc_l = clr_q ? '0 : {{2{sgn_q & res_q[ACC_LEN-1]}}, res_q};
    assign sum_l = acc_l + p_l;

    always_comb begin
        sat_hi = 1'b0;
        sat_lo = 1'b0;
        if (sgn_q) begin
            sat_hi = !sum_l[LX-1] && (sum_l[LX-2] || sum_l[LX-3]);
            sat_lo =  sum_l[LX-1] && !(sum_l[LX-2] && sum_l[LX-3]);
        end else begin
            sat_hi = |sum_l[LX-1:LX-2];
        end
        res_d = sum_l[ACC_LEN-1:0];
        if (sat_hi) begin
            res_d = sgn_q ? {1'b0, {(ACC_LEN-1){1'b1}}} : {ACC_LEN{1'b1}};
        end else if (sat_lo) begin
            res_d = {1'b1, {(ACC_LEN-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept && acc_clr) begin
            ovf_q <= 1'b0;
        end else if (state_q == FIN && (sat_hi || sat_lo)) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign acc_l = clr_q ? '0 : res_q;
    assign sum_l = acc_l + p_l;
    assign res_d = sum_l;
    assign ovf   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            clr_q   <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            if (accept) begin
                a_q   <= {{(PW-MUL_LEN){is_signed & a[MUL_LEN-1]}}, a};
                b_q   <= BWX'({{2{is_signed & b[MUL_LEN-1]}}, b, 1'b0});
                sgn_q <= is_signed;
                clr_q <= acc_clr;
            end else if (state_q == RUN) begin
                b_q <= b_q >> (2 * DPC);
            end
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            if (state_q == FIN) res_q <= res_d;
        end
    end

    assign result = res_q;

endmodule

// File: tb/tb_mac_booth_radix4_acc.sv
// Bench for mac_booth_radix4_acc: three instances (DPC 1/2/4, ACC_LEN 56/56/48) against an arithmetic MAC model.
module tb_mac_booth_radix4_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [23:0] a, b;
    logic        is_signed, acc_clr;
    logic [2:0]  in_valid_s, out_ready_s;
    wire  [2:0]  in_ready_s, out_valid_s, ovf_s;
    wire  [55:0] r0, r1;
    wire  [47:0] r2;

    int nvec = 0;
    int nerr = 0;

    logic [55:0] exp_res [3];
    logic        exp_ovf [3];

    mac_booth_radix4_acc #(.MUL_LEN(24), .ACC_LEN(56), .DPC(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a), .b(b), .is_signed(is_signed), .acc_clr(acc_clr),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .result(r0), .ovf(ovf_s[0]));

    mac_booth_radix4_acc #(.MUL_LEN(24), .ACC_LEN(56), .DPC(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a), .b(b), .is_signed(is_signed), .acc_clr(acc_clr),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .result(r1), .ovf(ovf_s[1]));

    mac_booth_radix4_acc #(.MUL_LEN(24), .ACC_LEN(48), .DPC(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .a(a), .b(b), .is_signed(is_signed), .acc_clr(acc_clr),
        .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .result(r2), .ovf(ovf_s[2]));

    function automatic int acc_len(input int k);
        return (k == 2) ? 48 : 56;
    endfunction

    function automatic int ncyc(input int k);
        case (k)
            0:       return 13;
            1:       return 7;
            default: return 4;
        endcase
    endfunction

    function automatic logic [55:0] res_of(input int k);
        case (k)
            0:       return r0;
            1:       return r1;
            default: return {8'h00, r2};
        endcase
    endfunction

    function automatic logic [55:0] msk(input int k);
        return (k == 2) ? 56'h0000_FFFF_FFFF_FFFF : 56'hFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: exact integer product added to the accumulator read in the current op's mode.
    task automatic model_apply(input int k, input logic [23:0] av, input logic [23:0] bv,
                               input logic s, input logic c);
        logic signed [127:0] pa, pb, acc, sum, one;
        int L;
`ifdef MAC_BOOTH_SAT_EN
        logic signed [127:0] hi, lo;
`endif
        L   = acc_len(k);
        one = 128'sd1;
        pa  = {{104{s & av[23]}}, av};
        pb  = {{104{s & bv[23]}}, bv};
        if (c) begin
            acc = 128'sd0;
            exp_ovf[k] = 1'b0;
        end else begin
            acc = {72'b0, exp_res[k]};
            if (s && exp_res[k][L-1]) acc = acc - (one <<< L);
        end
        sum = acc + pa * pb;
`ifdef MAC_BOOTH_SAT_EN
        hi = s ? (one <<< (L-1)) - one : (one <<< L) - one;
        lo = s ? -(one <<< (L-1)) : 128'sd0;
        if (sum > hi) begin
            sum = hi;
            exp_ovf[k] = 1'b1;
        end else if (sum < lo) begin
            sum = lo;
            exp_ovf[k] = 1'b1;
        end
`endif
        exp_res[k] = 56'(sum & ((one <<< L) - one));
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < 3; k++) begin
                if (out_valid_s[k]) begin
                    chk($sformatf("hold_result[%0d]", k), 64'(res_of(k)), 64'(exp_res[k]));
                    chk($sformatf("hold_ovf[%0d]", k), 64'(ovf_s[k]), 64'(exp_ovf[k]));
                    chk($sformatf("ready_excl[%0d]", k), 64'(in_ready_s[k]), 64'd0);
                end
            end
        end
    end

    task automatic do_op(input int k, input logic [23:0] av, input logic [23:0] bv,
                         input logic s, input logic c, input int hold);
        int edges, w;
        logic [55:0] held;
        w = 0;
        @(negedge clk);
        while (!in_ready_s[k] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("idle_ready[%0d]", k), 64'(in_ready_s[k]), 64'd1);
        a = av; b = bv; is_signed = s; acc_clr = c;
        in_valid_s[k] = 1'b1;
        model_apply(k, av, bv, s, c);
        @(posedge clk);
        #1;
        in_valid_s[k] = 1'b0;
        a = 24'($urandom); b = 24'($urandom);
        is_signed = 1'($urandom); acc_clr = 1'($urandom);
        edges = 0;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid_s[k]) break;
            chk($sformatf("busy_ready[%0d]", k), 64'(in_ready_s[k]), 64'd0);
        end
        chk($sformatf("latency[%0d]", k), 64'(edges), 64'(ncyc(k) + 1));
        held = res_of(k);
        for (int i = 0; i < hold; i++) begin
            in_valid_s[k] = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_valid[%0d]", k), 64'(out_valid_s[k]), 64'd1);
            chk($sformatf("bp_ready[%0d]", k), 64'(in_ready_s[k]), 64'd0);
            chk($sformatf("bp_result[%0d]", k), 64'(res_of(k)), 64'(held));
        end
        in_valid_s[k] = 1'b0;
        out_ready_s[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s[k] = 1'b0;
        @(negedge clk);
        chk($sformatf("post_valid[%0d]", k), 64'(out_valid_s[k]), 64'd0);
        chk($sformatf("post_ready[%0d]", k), 64'(in_ready_s[k]), 64'd1);
        chk($sformatf("post_result[%0d]", k), 64'(res_of(k)), 64'(held));
        if (hold > 0) begin
            @(negedge clk);
            chk($sformatf("no_queue[%0d]", k), 64'({out_valid_s[k], in_ready_s[k]}), 64'd1);
        end
    endtask

    task automatic chk_lit(input int k, input string nm, input logic [55:0] lit);
        chk($sformatf("%s[%0d]", nm, k), 64'(res_of(k)), 64'(lit & msk(k)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid_s = '0; out_ready_s = '0;
        a = '0; b = '0; is_signed = 1'b0; acc_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_res[k] = '0;
            exp_ovf[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_in_ready[%0d]", k), 64'(in_ready_s[k]), 64'd1);
            chk($sformatf("rst_out_valid[%0d]", k), 64'(out_valid_s[k]), 64'd0);
            chk($sformatf("rst_result[%0d]", k), 64'(res_of(k)), 64'd0);
            chk($sformatf("rst_ovf[%0d]", k), 64'(ovf_s[k]), 64'd0);
        end

        for (int k = 0; k < 3; k++) begin
            do_op(k, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 0);
            chk_lit(k, "umax_sq", 56'h0000_FFFF_FE00_0001);
            do_op(k, 24'h800000, 24'h7FFFFF, 1'b1, 1'b1, 0);
            chk_lit(k, "smin_x_smax", 56'hFF_C000_0080_0000);
            do_op(k, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 0);
            chk_lit(k, "neg1_sq", 56'd1);
            do_op(k, 24'd3, 24'd5, 1'b0, 1'b1, 0);
            chk_lit(k, "chain1", 56'd15);
            do_op(k, 24'd4, 24'd6, 1'b0, 1'b0, (k == 0) ? 5 : 0);
            chk_lit(k, "chain2", 56'd39);
            do_op(k, 24'hFFFFFE, 24'd7, 1'b1, 1'b0, 0);
            chk_lit(k, "chain3", 56'd25);
        end

        do_op(2, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 0);
        do_op(2, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 0);
`ifdef MAC_BOOTH_SAT_EN
        chk_lit(2, "acc48_sat", 56'h0000_FFFF_FFFF_FFFF);
        chk("acc48_ovf", 64'(ovf_s[2]), 64'd1);
`else
        chk_lit(2, "acc48_wrap", 56'h0000_FFFF_FC00_0002);
        chk("acc48_ovf", 64'(ovf_s[2]), 64'd0);
`endif
        do_op(2, 24'd3, 24'd5, 1'b0, 1'b1, 0);
        chk("acc48_ovf_clr", 64'(ovf_s[2]), 64'd0);
        chk_lit(2, "acc48_after_clr", 56'd15);

        // Abort instance 0 in its fifth RUN cycle.
        @(negedge clk);
        a = 24'd9; b = 24'd9; is_signed = 1'b0; acc_clr = 1'b0;
        in_valid_s[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_valid", 64'(out_valid_s[0]), 64'd0);
        chk("abort_result", 64'(r0), 64'd0);
        chk("abort_ready", 64'(in_ready_s[0]), 64'd1);
        chk("abort_ovf", 64'(ovf_s[0]), 64'd0);
        for (int k = 0; k < 3; k++) begin
            exp_res[k] = '0;
            exp_ovf[k] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(0, 24'd2, 24'd3, 1'b1, 1'b0, 0);
        chk_lit(0, "after_abort", 56'd6);

        for (int i = 0; i < 150; i++) begin
            do_op(int'($urandom_range(0, 2)), 24'($urandom), 24'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
